// File: rtl/rr_mux_arbiter.sv
// Round-robin scheduler for a shared N:1 mux: one owner per slot of SLOT cycles,
// with a one-cycle idle guard between owners so the output never switches mid-transfer.
module rr_mux_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 1,
    parameter int unsigned SLOT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*DW-1:0]      din,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] sel,
    output logic [DW-1:0]        dout,
    output logic                 valid,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned CW = $clog2(SLOT) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GUARD = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_nxt;
    logic [SW-1:0] sel_nxt;
    logic [SW-1:0] winner;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [N-1:0]  gnt_nxt;
    logic          valid_nxt;
    logic          busy_nxt;
    logic [DW-1:0] slice;

    // First requester after ptr, wrapping; ptr itself wins only when it is the sole requester.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = ptr;
        for (int unsigned i = N; i > 0; i--) begin
            idx = 32'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[SW'(idx)]) begin
                winner = SW'(idx);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        valid_nxt = valid;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    ptr_nxt   = winner;
                    sel_nxt   = winner;
                    cnt_nxt   = '0;
                    gnt_nxt   = N'(1) << winner;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            GRANT: begin
                cnt_nxt = cnt + CW'(1);
                if (!req[sel] || (cnt == CW'(SLOT - 1))) begin
                    state_nxt = GUARD;
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            end
            GUARD: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= SW'(N - 1);
            sel   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
        end
    end

    // Unregistered mux path, gated so nothing leaks out outside a grant.
    always_comb begin
        slice = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                slice = din[i*DW +: DW];
            end
        end
    end

    assign dout = slice & {DW{valid}};

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: three instances (SLOT 8, 2, 1) share one stimulus;
// grant order is scoreboarded, cycle behaviour checked against hand-derived timelines.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] sel_a, sel_b, sel_c;
    logic [0:0] dout_a, dout_b, dout_c;
    logic       valid_a, valid_b, valid_c;
    logic       busy_a, busy_b, busy_c;

    int total;
    int bad;

    int unsigned q_a[$];
    int unsigned q_b[$];
    logic        mon_a, mon_b;
    logic [3:0]  prev_a, prev_b;

    rr_mux_arbiter #(.N(4), .DW(1), .SLOT(8)) u_s8 (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_a), .sel(sel_a), .dout(dout_a), .valid(valid_a), .busy(busy_a)
    );

    rr_mux_arbiter #(.N(4), .DW(1), .SLOT(2)) u_s2 (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_b), .sel(sel_b), .dout(dout_b), .valid(valid_b), .busy(busy_b)
    );

    rr_mux_arbiter #(.N(4), .DW(1), .SLOT(1)) u_s1 (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_c), .sel(sel_c), .dout(dout_c), .valid(valid_c), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One step: just past the rising edge, where inputs are driven and outputs sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        din = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard for the SLOT=8 instance: each new grant pops the expected owner.
    always @(negedge clk) begin
        chk("onehot_a", 32'($onehot0(gnt_a)), 32'd1);
        if (mon_a && gnt_a != 4'd0 && prev_a == 4'd0) begin
            if (q_a.size() == 0) begin
                chk("sb_a_extra", 32'(gnt_a), 32'd0);
            end else begin
                chk("sb_a_sel", 32'(sel_a), q_a[0]);
                chk("sb_a_gnt", 32'(gnt_a), 32'd1 << q_a[0]);
                q_a.delete(0);
            end
        end
        prev_a <= gnt_a;
    end

    // Scoreboard for the SLOT=2 instance.
    always @(negedge clk) begin
        chk("onehot_b", 32'($onehot0(gnt_b)), 32'd1);
        if (mon_b && gnt_b != 4'd0 && prev_b == 4'd0) begin
            if (q_b.size() == 0) begin
                chk("sb_b_extra", 32'(gnt_b), 32'd0);
            end else begin
                chk("sb_b_sel", 32'(sel_b), q_b[0]);
                chk("sb_b_gnt", 32'(gnt_b), 32'd1 << q_b[0]);
                q_b.delete(0);
            end
        end
        prev_b <= gnt_b;
    end

    always @(negedge clk) begin
        chk("onehot_c", 32'($onehot0(gnt_c)), 32'd1);
    end

    initial begin
        total = 0;
        bad   = 0;
        mon_a = 1'b0;
        mon_b = 1'b0;
        rst   = 1'b1;
        req   = '0;
        din   = '0;

        // Reset state
        #1;
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_sel_a", 32'(sel_a), 32'd0);
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_dout_a", 32'(dout_a), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("rst_gnt_c", 32'(gnt_c), 32'd0);
        tick();
        rst = 1'b0;

        // Single requester, SLOT=8: 8 valid cycles, guard, idle, regrant
        do_reset();
        req = 4'b0100;
        din = 4'b0100;
        tick();
        chk("single_gnt", 32'(gnt_a), 32'h4);
        chk("single_sel", 32'(sel_a), 32'd2);
        chk("single_dout", 32'(dout_a), 32'd1);
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk("single_dout_hold", 32'(dout_a), 32'd1);
        end
        tick();
        chk("single_guard_gnt", 32'(gnt_a), 32'd0);
        chk("single_guard_valid", 32'(valid_a), 32'd0);
        chk("single_guard_busy", 32'(busy_a), 32'd1);
        tick();
        chk("single_idle_busy", 32'(busy_a), 32'd0);
        chk("single_idle_gnt", 32'(gnt_a), 32'd0);
        tick();
        chk("single_regrant", 32'(gnt_a), 32'h4);

        // Round-robin fairness, SLOT=2: order 0,1,2,3,0 with 2 valid / 2 idle
        do_reset();
        q_b.push_back(0);
        q_b.push_back(1);
        q_b.push_back(2);
        q_b.push_back(3);
        q_b.push_back(0);
        mon_b = 1'b1;
        req   = 4'b1111;
        for (int p = 1; p <= 18; p++) begin
            tick();
            chk("rr_valid", 32'(valid_b), (((p - 1) % 4) < 2) ? 32'd1 : 32'd0);
            if (((p - 1) % 4) < 2) begin
                chk("rr_sel", 32'(sel_b), 32'(((p - 1) / 4) % 4));
            end
        end
        mon_b = 1'b0;
        chk("rr_queue_empty", 32'(q_b.size()), 32'd0);

        // Early release: owner 1 drops after 3 cycles, pending 3 granted 2 edges later
        do_reset();
        q_a.push_back(1);
        q_a.push_back(3);
        mon_a = 1'b1;
        req   = 4'b1010;
        tick();
        chk("early_gnt1", 32'(gnt_a), 32'h2);
        chk("early_valid1", 32'(valid_a), 32'd1);
        tick();
        chk("early_gnt2", 32'(gnt_a), 32'h2);
        tick();
        chk("early_gnt3", 32'(gnt_a), 32'h2);
        req = 4'b1000;
        tick();
        chk("early_release_gnt", 32'(gnt_a), 32'd0);
        chk("early_release_busy", 32'(busy_a), 32'd1);
        tick();
        chk("early_idle_busy", 32'(busy_a), 32'd0);
        chk("early_idle_gnt", 32'(gnt_a), 32'd0);
        tick();
        chk("early_next_gnt", 32'(gnt_a), 32'h8);
        chk("early_next_sel", 32'(sel_a), 32'd3);

        // Mux transparency on owner 3, then gating once valid drops
        din = 4'b0000;
        #1 chk("mux_follow0", 32'(dout_a), 32'd0);
        din = 4'b1000;
        #1 chk("mux_follow1", 32'(dout_a), 32'd1);
        din = 4'b0000;
        #1 chk("mux_follow2", 32'(dout_a), 32'd0);
        req = 4'b0000;
        din = 4'b1111;
        tick();
        chk("mux_gate_valid", 32'(valid_a), 32'd0);
        chk("mux_gate_dout", 32'(dout_a), 32'd0);
        mon_a = 1'b0;
        chk("sb_a_queue_empty", 32'(q_a.size()), 32'd0);

        // Reset mid-grant: outputs clear without a clock, then arbitration restarts at 0
        do_reset();
        req = 4'b0011;
        din = 4'b0011;
        tick();
        chk("midrst_pre_gnt", 32'(gnt_a), 32'h1);
        chk("midrst_pre_dout", 32'(dout_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_gnt", 32'(gnt_a), 32'd0);
        chk("midrst_valid", 32'(valid_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_dout", 32'(dout_a), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_after_gnt", 32'(gnt_a), 32'h1);
        chk("midrst_after_sel", 32'(sel_a), 32'd0);

        // SLOT=1: drop coincides with slot expiry, single guard; grants last one cycle
        do_reset();
        req = 4'b0001;
        tick();
        chk("s1_gnt", 32'(gnt_c), 32'h1);
        chk("s1_valid", 32'(valid_c), 32'd1);
        req = 4'b0000;
        tick();
        chk("s1_guard_gnt", 32'(gnt_c), 32'd0);
        chk("s1_guard_valid", 32'(valid_c), 32'd0);
        chk("s1_guard_busy", 32'(busy_c), 32'd1);
        tick();
        chk("s1_idle_busy", 32'(busy_c), 32'd0);
        req = 4'b0011;
        tick();
        chk("s1_rr_gnt1", 32'(gnt_c), 32'h2);
        tick();
        chk("s1_rr_release", 32'(gnt_c), 32'd0);
        chk("s1_rr_busy", 32'(busy_c), 32'd1);
        tick();
        chk("s1_rr_idle", 32'(busy_c), 32'd0);
        tick();
        chk("s1_rr_gnt0", 32'(gnt_c), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one N:1 multiplexer output among N requesters. It grants one requester at a time and drives the mux select from the grant. It bounds each grant to a slot of SLOT cycles and inserts one idle guard cycle between owners, so the shared output never switches source mid-transfer. It sits in front of the mux datapath as its scheduler, in the combinational-logic/multiplexers area.

## Interface
- N, default 4: number of requesters; legal range 2..16.
- DW, default 1: data width per requester.
- SLOT, default 8: maximum consecutive cycles one owner may hold the grant; must be ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  N  request lines; req[i] high means requester i wants the output.
- din  input  N*DW  packed data; requester i occupies bits din[i*DW +: DW].
- gnt  output  N  one-hot grant, registered; all zeros when no owner.
- sel  output  clog2(N)  mux select, registered; equals the index of the owner.
- dout  output  DW  shared output; din slice at sel when valid, otherwise all zeros.
- valid  output  1  high while in GRANT.
- busy  output  1  high in GRANT and GUARD.

## Operation
- There are three states: IDLE, GRANT and GUARD.
- Registered state:
  - state;
  - owner index, which drives sel;
  - last-granted pointer ptr;
  - slot counter cnt, width clog2(SLOT)+1.
- Reset values:
  - state = IDLE, gnt = 0, sel = 0, valid = 0, busy = 0, dout = 0, cnt = 0;
  - ptr = N-1, so requester 0 has first priority.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the winner: the first index with req set, scanning ptr+1, ptr+2, … modulo N. If only req[ptr] is set, ptr itself wins.
  - On the next edge: gnt = one-hot(winner), sel = winner, ptr = winner, cnt = 0, state = GRANT.
- GRANT:
  - On each edge, cnt increments.
  - The grant is released at the edge where req[sel] is sampled low, or where cnt == SLOT-1 is sampled (the slot is exhausted).
  - On release: gnt = 0, state = GUARD.
  - Otherwise the grant holds.
- GUARD:
  - Lasts exactly one cycle with gnt = 0 and valid = 0, then returns to IDLE.
  - Requests sampled during GUARD are ignored.
- dout is combinational: din[sel*DW +: DW] AND-ed with valid. It has no register stage.
- Requests are level-sensitive, with no latching. A request dropped before it is granted is forgotten.
- A requester that is still requesting after a slot expiry competes normally. Because ptr now points at it, every other active requester is served before it.

## Timing
- Grant latency:
  - req rising, sampled at edge k while IDLE, gives gnt/valid high after edge k.
  - Best case the grant arrives 1 cycle after req is seen.
- Maximum grant length: SLOT cycles of valid, then 1 GUARD cycle, then 1 IDLE arbitration cycle.
- Back-to-back handoff between owners costs 2 cycles of valid = 0.
- Worst-case wait for requester i with all N requesting: (N-1)·(SLOT+2) cycles after its request is first seen.
- Simultaneous events:
  - If req[sel] drops on the same edge that the slot expires, there is a single release. GUARD is entered once.
  - With SLOT = 1, every grant lasts exactly 1 cycle.
- Asynchronous rst assertion at any time, including mid-GRANT:
  - gnt, valid, busy and dout go to 0 immediately, without waiting for an edge.
  - ptr returns to N-1.
  - After rst deasserts, the first edge with requests pending arbitrates from requester 0.
- gnt is always one-hot or zero; gnt, sel and valid change only on clk edges (apart from reset).

## Test plan
- **Reset mid-grant.** Assert rst while req = 4'b0011 and requester 0 is granted → gnt = 0, dout = 0 with no clock. After release, the first grant goes to req[0].
- **Single requester.** req = 4'b0100, din[2] = 1, SLOT = 8:
  - gnt = 4'b0100 and sel = 2 after one edge; dout = 1 for 8 cycles;
  - 1 GUARD cycle and 1 IDLE cycle follow, then gnt = 4'b0100 again.
- **Round-robin fairness.** req = 4'b1111 held, SLOT = 2 → grant order 0, 1, 2, 3, 0. Each grant has valid high for exactly 2 cycles, with a 2-cycle gap between grants.
- **Early release.** req[1] high for 3 cycles after its grant, then low → gnt clears at that edge. Requester 3, pending, is granted 2 edges later.
- **Mux transparency.** Owner 3 granted with din[3] toggling 0 → 1 → 0 → dout follows the same cycle. dout = 0 whenever valid = 0, even if din is all ones.
- **Simultaneous release and drop, SLOT = 1.** req[0] drops exactly at slot expiry → exactly one GUARD cycle follows. gnt is never non-one-hot, as checked by an assertion every cycle.
